// File: rtl/trace_filter_pkg.sv
// Shared constants for the multi-rule trace filter: filter modes and default widths.
package trace_filter_pkg;

    localparam int DEF_INSTR_WIDTH = 32;
    localparam int DEF_NUM_RULES   = 4;
    localparam int DEF_CNT_WIDTH   = 32;

    localparam logic MODE_DENY  = 1'b0;
    localparam logic MODE_ALLOW = 1'b1;

    // In allowlist mode a miss drops the word, so no enabled rule means drop everything.
    function automatic logic classify_drop(input logic mode, input logic any_hit);
        return (mode == MODE_ALLOW) ? ~any_hit : any_hit;
    endfunction

endpackage

// File: rtl/trace_filter_rule.sv
// One mask/match rule: holds enable, mask and match registers and compares the live instruction.
module trace_filter_rule #(
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   wr_enable,
    input  logic [INSTR_WIDTH-1:0] wr_mask,
    input  logic [INSTR_WIDTH-1:0] wr_match,
    input  logic [INSTR_WIDTH-1:0] instr,
    output logic                   hit
);

    logic                   enable_q;
    logic [INSTR_WIDTH-1:0] mask_q;
    logic [INSTR_WIDTH-1:0] match_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            enable_q <= 1'b0;
            mask_q   <= '0;
            match_q  <= '0;
        end else if (wr_en) begin
            enable_q <= wr_enable;
            mask_q   <= wr_mask;
            match_q  <= wr_match;
        end
    end

    assign hit = enable_q && ((instr & mask_q) == (match_q & mask_q));

endmodule

// File: rtl/multi_rule_trace_filter.sv
// Trace-word filter: classifies each accepted word against NUM_RULES mask/match rules,
// registers the verdict with a valid/ready output stage and keeps saturating statistics.
module multi_rule_trace_filter
    import trace_filter_pkg::*;
#(
    parameter int INSTR_WIDTH = DEF_INSTR_WIDTH,
    parameter int NUM_RULES   = DEF_NUM_RULES,
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
    localparam int IDX_W      = (NUM_RULES > 1) ? $clog2(NUM_RULES) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_WIDTH-1:0] instr,
    input  logic                   mode,
    input  logic                   cfg_wr_en,
    input  logic [IDX_W-1:0]       cfg_idx,
    input  logic                   cfg_enable,
    input  logic [INSTR_WIDTH-1:0] cfg_mask,
    input  logic [INSTR_WIDTH-1:0] cfg_match,
    input  logic                   cnt_clear,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INSTR_WIDTH-1:0] out_instr,
    output logic                   drop_instr,
    output logic [NUM_RULES-1:0]   rule_hit,
    output logic [CNT_WIDTH-1:0]   kept_count,
    output logic [CNT_WIDTH-1:0]   dropped_count
);

    logic [NUM_RULES-1:0] hit_now;
    logic                 drop_now;
    logic                 accept;

    // Indices at or beyond NUM_RULES match no rule and so write nothing.
    for (genvar i = 0; i < NUM_RULES; i++) begin : g_rule
        trace_filter_rule #(
            .INSTR_WIDTH(INSTR_WIDTH)
        ) u_rule (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (cfg_wr_en && (cfg_idx == IDX_W'(i))),
            .wr_enable(cfg_enable),
            .wr_mask  (cfg_mask),
            .wr_match (cfg_match),
            .instr    (instr),
            .hit      (hit_now[i])
        );
    end

    assign drop_now = classify_drop(mode, |hit_now);
    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_instr  <= '0;
            drop_instr <= 1'b0;
            rule_hit   <= '0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_instr  <= instr;
            drop_instr <= drop_now;
            rule_hit   <= hit_now;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clear) begin
            kept_count    <= '0;
            dropped_count <= '0;
        end else if (accept) begin
            if (drop_now) begin
                if (dropped_count != '1) dropped_count <= dropped_count + 1'b1;
            end else begin
                if (kept_count != '1) kept_count <= kept_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multi_rule_trace_filter.sv
// Self-checking bench for multi_rule_trace_filter: vector table plus handshake/config/reset sequences.
module tb_multi_rule_trace_filter;

    localparam int W  = 32;
    localparam int NR = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  instr;
    logic          mode;
    logic          cfg_wr_en;
    logic [1:0]    cfg_idx;
    logic          cfg_enable;
    logic [W-1:0]  cfg_mask;
    logic [W-1:0]  cfg_match;
    logic          cnt_clear;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_instr;
    logic          drop_instr;
    logic [NR-1:0] rule_hit;
    logic [CW-1:0] kept_count;
    logic [CW-1:0] dropped_count;

    multi_rule_trace_filter #(
        .INSTR_WIDTH(W),
        .NUM_RULES  (NR),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .instr        (instr),
        .mode         (mode),
        .cfg_wr_en    (cfg_wr_en),
        .cfg_idx      (cfg_idx),
        .cfg_enable   (cfg_enable),
        .cfg_mask     (cfg_mask),
        .cfg_match    (cfg_match),
        .cnt_clear    (cnt_clear),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .drop_instr   (drop_instr),
        .rule_hit     (rule_hit),
        .kept_count   (kept_count),
        .dropped_count(dropped_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  instr;
        logic          mode;
        logic          drop;
        logic [NR-1:0] hit;
    } vec_t;

    typedef struct {
        logic [W-1:0]  instr;
        logic          drop;
        logic [NR-1:0] hit;
    } exp_t;

    vec_t vecs[8];
    exp_t sb_q[$];

    logic          exp_drop;
    logic [NR-1:0] exp_hit;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Output side of the scoreboard: pop on handshake, push on accept.
    always @(negedge clk) begin
        if (rst) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_output", out_instr, '0);
                    n_fail++;
                    n_vec++;
                    $display("FAIL sb_empty: output 0x%0h with no expected entry", out_instr);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("sb_instr", out_instr, e.instr);
                    check("sb_drop", W'(drop_instr), W'(e.drop));
                    check("sb_hit", W'(rule_hit), W'(e.hit));
                end
            end
            if (in_valid && in_ready) begin
                exp_t e;
                e.instr = instr;
                e.drop  = exp_drop;
                e.hit   = exp_hit;
                sb_q.push_back(e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic probe();
        @(posedge clk);
        #2;
    endtask

    task automatic cfg_rule(input logic [1:0] idx, input logic en, input logic [W-1:0] m, input logic [W-1:0] v);
        cfg_wr_en  = 1'b1;
        cfg_idx    = idx;
        cfg_enable = en;
        cfg_mask   = m;
        cfg_match  = v;
        tick();
        cfg_wr_en  = 1'b0;
    endtask

    task automatic clear_counts();
        cnt_clear = 1'b1;
        tick();
        cnt_clear = 1'b0;
    endtask

    task automatic send(input logic [W-1:0] w, input logic m, input logic d, input logic [NR-1:0] h);
        in_valid = 1'b1;
        instr    = w;
        mode     = m;
        exp_drop = d;
        exp_hit  = h;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{32'h0000_006F, 1'b1, 1'b0, 4'b0001};
        vecs[1] = '{32'h00C5_8063, 1'b1, 1'b0, 4'b0100};
        vecs[2] = '{32'h00A3_0293, 1'b1, 1'b1, 4'b0000};
        vecs[3] = '{32'h0000_0067, 1'b1, 1'b0, 4'b0010};
        vecs[4] = '{32'h0000_006F, 1'b0, 1'b1, 4'b0001};
        vecs[5] = '{32'h00C5_8063, 1'b0, 1'b1, 4'b0100};
        vecs[6] = '{32'h00A3_0293, 1'b0, 1'b0, 4'b0000};
        vecs[7] = '{32'h0000_0067, 1'b0, 1'b1, 4'b0010};

        rst = 1'b1; in_valid = 1'b0; instr = '0; mode = 1'b1;
        cfg_wr_en = 1'b0; cfg_idx = '0; cfg_enable = 1'b0; cfg_mask = '0; cfg_match = '0;
        cnt_clear = 1'b0; out_ready = 1'b1; exp_drop = 1'b0; exp_hit = '0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("reset_out_valid", W'(out_valid), 0);
        check("reset_in_ready", W'(in_ready), 1);
        check("reset_kept", W'(kept_count), 0);
        check("reset_dropped", W'(dropped_count), 0);
        check("reset_rule_hit", W'(rule_hit), 0);

        cfg_rule(2'd0, 1'b1, 32'h7F, 32'h6F);
        cfg_rule(2'd1, 1'b1, 32'h7F, 32'h67);
        cfg_rule(2'd2, 1'b1, 32'h7F, 32'h63);

        // Allowlist then denylist over the same four-word stream.
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].instr, vecs[i].mode, vecs[i].drop, vecs[i].hit);
            tick();
            if (i == 3 || i == 7) begin
                in_valid = 1'b0;
                probe();
                check(i == 3 ? "allow_kept" : "deny_kept", W'(kept_count), i == 3 ? 3 : 1);
                check(i == 3 ? "allow_dropped" : "deny_dropped", W'(dropped_count), i == 3 ? 1 : 3);
                #1;
                clear_counts();
            end
        end

        // Backpressure: held result must stay put and block further accepts.
        out_ready = 1'b0;
        send(32'h0000_006F, 1'b1, 1'b0, 4'b0001);
        tick();
        send(32'h00C5_8063, 1'b1, 1'b0, 4'b0100);
        for (int c = 0; c < 3; c++) begin
            probe();
            check("stall_in_ready", W'(in_ready), 0);
            check("stall_out_valid", W'(out_valid), 1);
            check("stall_out_instr", out_instr, 32'h0000_006F);
            check("stall_hit", W'(rule_hit), W'(4'b0001));
            check("stall_kept", W'(kept_count), 1);
        end
        #1;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
        check("release_out_instr", out_instr, 32'h00C5_8063);
        check("release_kept", W'(kept_count), 2);
        tick();
        clear_counts();

        // Rule write and accept in the same cycle: the accepted word still sees the old rule.
        cfg_wr_en = 1'b1; cfg_idx = 2'd0; cfg_enable = 1'b0; cfg_mask = 32'h7F; cfg_match = 32'h6F;
        send(32'h0000_006F, 1'b1, 1'b0, 4'b0001);
        tick();
        cfg_wr_en = 1'b0;
        send(32'h0000_006F, 1'b1, 1'b1, 4'b0000);
        tick();
        in_valid = 1'b0;
        probe();
        check("cfgrace_kept", W'(kept_count), 1);
        check("cfgrace_dropped", W'(dropped_count), 1);
        #1;
        clear_counts();

        // Saturation of the 4-bit kept counter, then clear beating a same-cycle accept.
        cfg_rule(2'd0, 1'b1, 32'h7F, 32'h6F);
        for (int k = 0; k < 20; k++) begin
            send(32'h0000_006F, 1'b1, 1'b0, 4'b0001);
            tick();
        end
        in_valid = 1'b0;
        probe();
        check("sat_kept", W'(kept_count), 32'hF);
        check("sat_dropped", W'(dropped_count), 0);
        #1;
        cnt_clear = 1'b1;
        send(32'h0000_006F, 1'b1, 1'b0, 4'b0001);
        tick();
        cnt_clear = 1'b0;
        in_valid = 1'b0;
        #1;
        check("clrpri_kept", W'(kept_count), 0);
        check("clrpri_dropped", W'(dropped_count), 0);
        tick();

        // Reset while a result is held under backpressure.
        out_ready = 1'b0;
        send(32'h00A3_0293, 1'b1, 1'b1, 4'b0000);
        tick();
        in_valid = 1'b0;
        check("prerst_out_valid", W'(out_valid), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("rst_out_valid", W'(out_valid), 0);
        check("rst_in_ready", W'(in_ready), 1);
        check("rst_kept", W'(kept_count), 0);
        check("rst_dropped", W'(dropped_count), 0);
        out_ready = 1'b1;
        send(32'h0000_006F, 1'b1, 1'b1, 4'b0000);
        tick();
        in_valid = 1'b0;
        tick();
        #1;
        check("postrst_dropped", W'(dropped_count), 1);
        check("postrst_kept", W'(kept_count), 0);
        check("sb_drained", W'(sb_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_rule_trace_filter.md
MULTI_RULE_TRACE_FILTER -- requirements
Module: multi_rule_trace_filter

Interface
- REQ-001 Parameter INSTR_WIDTH, default 32, instruction word width.
- REQ-002 Parameter NUM_RULES, default 4, number of mask/match rules (1..16).
- REQ-003 Parameter CNT_WIDTH, default 32, width of kept/dropped counters.
- REQ-004 clk  in  1  single clock; all state updates on rising edge.
- REQ-005 rst  in  1  reset, synchronous and active-high.
- REQ-006 in_valid  in  1  instr carries a trace word this cycle.
- REQ-007 in_ready  out  1  filter can accept a word this cycle.
- REQ-008 instr  in  INSTR_WIDTH  trace instruction word.
- REQ-009 mode  in  1  0 = denylist (drop on hit), 1 = allowlist (keep on hit).
- REQ-010 cfg_wr_en  in  1  write one rule this cycle.
- REQ-011 cfg_idx  in  max(1,$clog2(NUM_RULES))  rule index written.
- REQ-012 cfg_enable  in  1  rule enable value written.
- REQ-013 cfg_mask / cfg_match  in  INSTR_WIDTH each  rule mask and compare value.
- REQ-014 cnt_clear  in  1  clear both counters.
- REQ-015 out_valid  out  1  registered result present.
- REQ-016 out_ready  in  1  downstream accepts result.
- REQ-017 out_instr  out  INSTR_WIDTH  word that produced the result.
- REQ-018 drop_instr  out  1  word to be dropped from trace.
- REQ-019 rule_hit  out  NUM_RULES  per-rule hit vector for out_instr.
- REQ-020 kept_count / dropped_count  out  CNT_WIDTH each  accepted-word statistics.

Function
- REQ-021 Rule i SHALL hit when enable_i and (instr & mask_i) == (match_i & mask_i).
- REQ-022 drop SHALL be (|hit) in mode 0, ~(|hit) in mode 1; allowlist with no enabled rule drops every word.
- REQ-023 Accept SHALL occur when in_valid && in_ready; in_ready SHALL be ~out_valid | out_ready (combinational, no in_valid dependency).
- REQ-024 On accept, out_valid, out_instr, drop_instr, rule_hit SHALL update on the next edge (latency 1); throughput 1 word/cycle with out_ready high.
- REQ-025 While out_valid && ~out_ready, all outputs SHALL hold stable and no word is accepted.
- REQ-026 out_valid SHALL clear after an output handshake with no same-cycle accept.
- REQ-027 Classification SHALL use mode and rules sampled at accept; later changes do not alter a held result.
- REQ-028 Rule write SHALL take effect the edge after cfg_wr_en; a word accepted the same cycle uses the old rule.
- REQ-029 cfg_idx >= NUM_RULES SHALL be ignored.
- REQ-030 On accept, exactly one of kept_count/dropped_count SHALL increment, saturating at all-ones.
- REQ-031 cnt_clear SHALL zero both counters and take priority over a same-cycle increment.

Reset
- REQ-032 rst SHALL clear out_valid, out_instr, drop_instr, rule_hit, both counters, and all rule enable/mask/match registers to 0.
- REQ-033 rst mid-transfer SHALL discard any held result; in_ready SHALL be 1 the cycle after rst deasserts.
- REQ-034 rst SHALL override cfg_wr_en, cnt_clear and accept in the same cycle.

Structure
- REQ-035 Package trace_filter_pkg SHALL hold MODE_DENY/MODE_ALLOW constants and default width constants.
- REQ-036 Sub-module trace_filter_rule SHALL hold one rule's registers and comparator, instantiated NUM_RULES times.

Verification (rules: r0 mask 0x7F match 0x6F, r1 0x7F/0x67, r2 0x7F/0x63, all enabled)
- REQ-037 mode=1, stream 0x0000006F, 0x00C58063, 0x00A30293, 0x00000067 -> drop 0,0,1,0; rule_hit 0001,0100,0000,0010; kept=3, dropped=1.
- REQ-038 mode=0, same stream -> drop inverted; kept=1, dropped=3.
- REQ-039 out_ready low 3 cycles holding 0x0000006F -> in_ready=0, outputs stable, no count change; release -> next word accepted next cycle.
- REQ-040 cfg_wr_en disabling r0 in the same cycle 0x0000006F is accepted (mode=1) -> kept; next 0x0000006F -> dropped.
- REQ-041 CNT_WIDTH=4, 20 kept words -> kept_count holds 0xF; cnt_clear with accept -> both 0.
- REQ-042 rst with out_valid=1, out_ready=0 -> next cycle out_valid=0, counters 0, all rules disabled (mode=1 drops 0x0000006F).
